spi_read_sched: RTL and testbench
=================================

SPI_READ_SCHED -- requirements
Module: spi_read_sched

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 40_000, clk cycles from end of one read transaction to the next rd assertion (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4_096, maximum cycles rd may stay high without d_ready (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst_l  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits periodic read scheduling.
REQ-006 SHALL have port d_ready  input  1  SPI master word-complete flag.
REQ-007 SHALL have port d  input  16  SPI master received word; valid while d_ready high.
REQ-008 SHALL have port rd  output  1  read request to the SPI master.
REQ-009 SHALL have port sample  output  16  last captured (or averaged) word; holds between updates.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse, the cycle sample updates.
REQ-011 SHALL have port timeout_err  output  1  sticky; set on timeout, cleared on next successful capture.
REQ-012 SHALL have port busy  output  1  high in REQ and RELEASE states.
REQ-013 SHALL have port sample_count  output  8  count of successful captures, wraps 255->0.

Function
REQ-014 SHALL implement states IDLE, WAIT_TMR, REQ, RELEASE; all outputs registered.
REQ-015 IDLE: enable=1 -> WAIT_TMR with timer loaded to REFRESH_PERIOD-1.
REQ-016 WAIT_TMR: timer decrements each cycle; at 0 -> REQ; enable=0 -> IDLE (timer not reloaded until re-entry).
REQ-017 REQ: rd=1 starting the first cycle in REQ; timeout counter starts at 0 and increments each cycle.
REQ-018 REQ with d_ready=1: next cycle rd=0, sample<=d, sample_valid=1, sample_count+1, timeout_err<=0, -> RELEASE.
REQ-019 REQ with counter = TIMEOUT_CYCLES-1 and d_ready=0: next cycle rd=0, timeout_err<=1, sample unchanged, no pulse, -> RELEASE.
REQ-020 d_ready and timeout in the same cycle: capture (REQ-018) wins.
REQ-021 RELEASE: wait for d_ready=0; then -> WAIT_TMR with timer reloaded if enable=1, else IDLE.
REQ-022 enable dropping during REQ or RELEASE SHALL NOT abort; transaction completes and the FSM returns to IDLE.
REQ-023 d_ready high outside REQ SHALL be ignored (no capture, no pulse).
REQ-024 Read period SHALL be exactly REFRESH_PERIOD cycles WAIT_TMR + handshake cycles; no drift.

Reset
REQ-025 rst_l=0 SHALL asynchronously force: state IDLE, rd=0, sample=0, sample_valid=0, timeout_err=0, busy=0, sample_count=0, timers=0, average history=0.
REQ-026 Reset mid-REQ SHALL drop rd immediately; no capture on release; after release, first rd no earlier than REFRESH_PERIOD+1 cycles.

Configuration
REQ-027 Macro SPI_SCHED_AVG_EN defined: sample = floor of the mean of the last 4 captured words (18-bit sum, >>2); history resets to 0, so the first three outputs include zeros.
REQ-028 SPI_SCHED_AVG_EN undefined: sample = raw captured d; no history registers synthesized.
REQ-029 All other behaviour, including timing of sample_valid, SHALL be identical with and without the macro.

Verification (REFRESH_PERIOD=8, TIMEOUT_CYCLES=16)
REQ-030 enable=1 after reset, d_ready driven 3 cycles after rd rises with d=16'hA5A5 -> rd high 8 cycles after WAIT_TMR entry; sample=16'hA5A5, one sample_valid pulse, sample_count=1.
REQ-031 d_ready never asserted -> rd high exactly 16 cycles, then timeout_err=1, sample unchanged; next read succeeds -> timeout_err=0.
REQ-032 d_ready asserted on the 16th REQ cycle -> capture, timeout_err stays 0.
REQ-033 enable=0 during REQ -> transaction completes, FSM goes to IDLE, no further rd; re-enable -> rd after 8 cycles.
REQ-034 AVG_EN, captures 16'd4, 16'd8, 16'd12, 16'd16 -> sample 1, 3, 6, 10; with AVG_EN undefined -> 4, 8, 12, 16.
REQ-035 rst_l pulsed low mid-REQ -> rd=0 that cycle, all outputs at reset values; 256 captures -> sample_count wraps to 0.

Source files
------------

// File: rtl/spi_read_sched.sv
// spi_read_sched: periodic SPI read scheduler with timeout and optional averaging.
// Ports: clk, rst_l (async low), enable, d_ready, d[15:0] in; rd, sample[15:0],
//   sample_valid, timeout_err, busy, sample_count[7:0] out (all registered).
// Macro SPI_SCHED_AVG_EN: sample becomes the mean of the last four captures.
module spi_read_sched #(
  parameter int unsigned REFRESH_PERIOD = 40_000,
  parameter int unsigned TIMEOUT_CYCLES = 4_096
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        enable,
  input  logic        d_ready,
  input  logic [15:0] d,
  output logic        rd,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic        busy,
  output logic [7:0]  sample_count
);

  localparam int TW  = $clog2(REFRESH_PERIOD);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  localparam logic [TW-1:0]  T_LOAD  =
    TW'(REFRESH_PERIOD - 1);
  localparam logic [TCW-1:0] TC_LAST =
    TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TMR,
    REQ,
    RELEASE
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [TCW-1:0] tcnt;
  logic [15:0]    cap_word;

`ifdef SPI_SCHED_AVG_EN
  logic [15:0] h0;
  logic [15:0] h1;
  logic [15:0] h2;
  logic [17:0] avg_sum;
  logic        cap_fire;

  // Mean of the incoming word and the three previous captures.
  assign avg_sum = {2'b00, d}  + {2'b00, h0}
                 + {2'b00, h1} + {2'b00, h2};
  assign cap_word = 16'(avg_sum >> 2);
  assign cap_fire = (state == REQ) && d_ready;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
    end else if (cap_fire) begin
      h0 <= d;
      h1 <= h0;
      h2 <= h1;
    end
  end
`else
  assign cap_word = d;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= IDLE;
      timer        <= '0;
      tcnt         <= '0;
      rd           <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      sample_count <= '0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT_TMR;
            timer <= T_LOAD;
          end
        end
        WAIT_TMR: begin
          if (!enable) begin
            state <= IDLE;
          end else if (timer == '0) begin
            state <= REQ;
            rd    <= 1'b1;
            busy  <= 1'b1;
            tcnt  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        REQ: begin
          // A word arriving on the last allowed cycle still counts.
          if (d_ready) begin
            state        <= RELEASE;
            rd           <= 1'b0;
            sample       <= cap_word;
            sample_valid <= 1'b1;
            sample_count <= sample_count + 8'd1;
            timeout_err  <= 1'b0;
          end else if (tcnt == TC_LAST) begin
            state       <= RELEASE;
            rd          <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RELEASE: begin
          // Hold off until the master drops its flag so one
          // word is never captured twice.
          if (!d_ready) begin
            busy <= 1'b0;
            if (enable) begin
              state <= WAIT_TMR;
              timer <= T_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_read_sched.sv
// tb_spi_read_sched: scoreboard bench for spi_read_sched.
// Runs with REFRESH_PERIOD=8, TIMEOUT_CYCLES=16.
module tb_spi_read_sched;

  localparam int RP = 8;
  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        enable;
  logic        d_ready;
  logic [15:0] d;
  logic        rd;
  logic [15:0] sample;
  logic        sample_valid;
  logic        timeout_err;
  logic        busy;
  logic [7:0]  sample_count;

  always #5 clk = ~clk;

  spi_read_sched #(
    .REFRESH_PERIOD(RP),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .enable(enable),
    .d_ready(d_ready),
    .d(d),
    .rd(rd),
    .sample(sample),
    .sample_valid(sample_valid),
    .timeout_err(timeout_err),
    .busy(busy),
    .sample_count(sample_count)
  );

  typedef struct packed {
    logic [15:0] s;
    logic [7:0]  c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_s;
  logic [7:0]  exp_cnt;
`ifdef SPI_SCHED_AVG_EN
  logic [15:0] h0, h1, h2;
`endif

  task automatic reset_model();
    sb.delete();
    exp_cnt = 8'd0;
    last_s  = 16'd0;
`ifdef SPI_SCHED_AVG_EN
    h0 = 16'd0;
    h1 = 16'd0;
    h2 = 16'd0;
`endif
  endtask

  task automatic push_exp(input logic [15:0] v);
    exp_t e;
`ifdef SPI_SCHED_AVG_EN
    logic [17:0] sum;
    sum = {2'b00, v} + {2'b00, h0} + {2'b00, h1} + {2'b00, h2};
    e.s = sum[17:2];
    h2 = h1;
    h1 = h0;
    h0 = v;
`else
    e.s = v;
`endif
    exp_cnt = exp_cnt + 8'd1;
    e.c = exp_cnt;
    last_s = e.s;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_l === 1'b1 && sample_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse sample=%h count=%0d",
                 sample, sample_count);
      end else begin
        e = sb.pop_front();
        if ({sample, sample_count} !== {e.s, e.c}) begin
          bad++;
          $display("FAIL capture got=%h/%0d exp=%h/%0d",
                   sample, sample_count, e.s, e.c);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int max, output int n);
    n = 0;
    while (rd !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    if (rd !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL rd_wait got=timeout after %0d", n);
    end
  endtask

  task automatic do_read(input logic [15:0] v, input int dly);
    int n;
    wait_rd(40, n);
    repeat (dly) tick();
    d       = v;
    d_ready = 1'b1;
    push_exp(v);
    tick();
    total++;
    if (rd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rd_drop got rd=%b busy=%b exp rd=0 busy=1",
               rd, busy);
    end
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b exp=0", timeout_err);
    end
    d_ready = 1'b0;
    tick();
    total++;
    if (sample_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width got valid=%b busy=%b exp 0 0",
               sample_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_l   = 1'b0;
    enable  = 1'b0;
    d_ready = 1'b0;
    d       = 16'd0;
    reset_model();
    repeat (3) tick();
    total++;
    if ({rd, sample_valid, timeout_err, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {rd, sample_valid, timeout_err, busy});
    end
    total++;
    if ({sample, sample_count} !== 24'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%0d exp=0/0",
               sample, sample_count);
    end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    enable = 1'b1;
    wait_rd(40, n);
    total++;
    if (n !== RP + 1) begin
      bad++;
      $display("FAIL first_latency got=%0d exp=%0d", n, RP + 1);
    end
    do_read(16'hA5A5, 3);
    total++;
    if (sample !== last_s) begin
      bad++;
      $display("FAIL basic_sample got=%h exp=%h", sample, last_s);
    end
    total++;
    if (sample_count !== 8'd1) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=1", sample_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    int cnt;
    wait_rd(40, n);
    total++;
    if (n !== RP) begin
      bad++;
      $display("FAIL period got=%0d exp=%0d", n, RP);
    end
    cnt = 1;
    while (cnt < 100) begin
      tick();
      if (rd !== 1'b1) break;
      cnt++;
    end
    total++;
    if (cnt !== TC) begin
      bad++;
      $display("FAIL rd_high_len got=%0d exp=%0d", cnt, TC);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_set got=%b exp=1", timeout_err);
    end
    total++;
    if ({sample, sample_count} !== {last_s, exp_cnt}) begin
      bad++;
      $display("FAIL timeout_hold got=%h/%0d exp=%h/%0d",
               sample, sample_count, last_s, exp_cnt);
    end
    do_read(16'h1234, 0);
  endtask

  task automatic test_late();
    do_read(16'h0F0F, TC - 1);
    total++;
    if (sample !== last_s) begin
      bad++;
      $display("FAIL late_sample got=%h exp=%h", sample, last_s);
    end
  endtask

  task automatic test_enable_drop();
    int  n;
    logic seen;
    wait_rd(40, n);
    enable = 1'b0;
    do_read(16'h5A5A, 2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      d       = 16'hDEAD;
      d_ready = (i % 4 == 1);
      tick();
      if (rd !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet got=activity exp=none");
    end
    total++;
    if (sample_count !== exp_cnt) begin
      bad++;
      $display("FAIL ignore_ready got=%0d exp=%0d",
               sample_count, exp_cnt);
    end
    d_ready = 1'b0;
    tick();
    enable = 1'b1;
    wait_rd(40, n);
    total++;
    if (n !== RP + 1) begin
      bad++;
      $display("FAIL reenable_latency got=%0d exp=%0d", n, RP + 1);
    end
    do_read(16'h0001, 1);
  endtask

  task automatic test_avg();
    logic [15:0] vals [4];
    logic [15:0] want [4];
    vals = '{16'd4, 16'd8, 16'd12, 16'd16};
`ifdef SPI_SCHED_AVG_EN
    want = '{16'd1, 16'd3, 16'd6, 16'd10};
`else
    want = '{16'd4, 16'd8, 16'd12, 16'd16};
`endif
    rst_l = 1'b0;
    reset_model();
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(vals[i], 2);
      total++;
      if (sample !== want[i]) begin
        bad++;
        $display("FAIL avg_%0d got=%0d exp=%0d", i, sample, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    int n;
    wait_rd(40, n);
    repeat (2) tick();
    d       = 16'hFFFF;
    d_ready = 1'b1;
    #2;
    rst_l = 1'b0;
    #1;
    total++;
    if ({rd, sample_valid, timeout_err, busy} !== 4'b0) begin
      bad++;
      $display("FAIL midreq_flags got=%b exp=0000",
               {rd, sample_valid, timeout_err, busy});
    end
    total++;
    if ({sample, sample_count} !== 24'd0) begin
      bad++;
      $display("FAIL midreq_data got=%h/%0d exp=0/0",
               sample, sample_count);
    end
    reset_model();
    tick();
    rst_l   = 1'b1;
    d_ready = 1'b0;
    wait_rd(40, n);
    total++;
    if (n < RP + 1) begin
      bad++;
      $display("FAIL post_reset_latency got=%0d exp>=%0d", n, RP + 1);
    end
    do_read(16'hBEEF, 0);
    for (int i = 0; i < 255; i++) begin
      do_read(16'(i * 257), 0);
    end
    total++;
    if (sample_count !== 8'd0) begin
      bad++;
      $display("FAIL count_wrap got=%0d exp=0", sample_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_late();
    test_enable_drop();
    test_avg();
    test_reset_mid_req();
    repeat (2) tick();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL missing_pulses got=%0d pending exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
